uart_rx8: RTL and testbench

UART_RX8 -- requirements
Module: uart_rx8

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rx_sync.sv | 21 ++
 rtl/uart_rx8.sv | 130 +++++++++++++
 tb/tb_uart_rx8.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8x-oversampled UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    localparam int unsigned OVERSAMPLE_DEF = 8;
    localparam int unsigned DATA_BITS_DEF  = 8;

    // Majority-vote sample points within a bit, centred on tick 4 of 0..7.
    localparam logic [2:0] SAMPLE_A = 3'd3;
    localparam logic [2:0] SAMPLE_B = 3'd4;
    localparam logic [2:0] SAMPLE_C = 3'd5;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx8.sv
// UART receiver: 8x oversampling, 3-sample majority vote per bit, LSB first.
module uart_rx8
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud8_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned IdxW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [2:0]  TickLast  = 3'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] BitLast = IdxW'(DATA_BITS - 1);

    logic                 rxs;
    state_e               state_q, state_d;
    logic [2:0]           tick_q, tick_d, tick_cur;
    logic [IdxW-1:0]      bit_q, bit_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 maj;

    rx_sync u_rx_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (rxd),
        .q_o   (rxs)
    );

    always_comb begin
        tick_cur = tick_q + 3'd1;
        maj      = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs) | (samp_q[0] & rxs);
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        samp_d   = samp_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;

        if (baud8_tick) begin
            case (state_q)
                StIdle: begin
                    // This tick is tick 0 of the start bit.
                    if (!rxs) begin
                        state_d = StStart;
                        tick_d  = 3'd0;
                        bit_d   = '0;
                    end
                end
                StBreak: begin
                    if (rxs) state_d = StIdle;
                end
                default: begin
                    tick_d = tick_cur;
                    if (tick_cur == SAMPLE_A) samp_d[0] = rxs;
                    if (tick_cur == SAMPLE_B) samp_d[1] = rxs;
                    if (tick_cur == SAMPLE_C) begin
                        if (state_q == StStart) begin
                            if (maj) state_d = StIdle;
                        end else if (state_q == StData) begin
                            shift_d = DATA_BITS'({maj, shift_q} >> 1);
                        end else begin
                            // Stop decided early so an immediate next start edge is caught.
                            if (maj) begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                                state_d = StIdle;
                            end else begin
                                ferr_d  = 1'b1;
                                state_d = StBreak;
                            end
                        end
                    end
                    if (tick_cur == TickLast) begin
                        if (state_q == StStart) begin
                            state_d = StData;
                            bit_d   = '0;
                        end else if (state_q == StData) begin
                            if (bit_q == BitLast) begin
                                state_d = StStop;
                            end else begin
                                bit_d = bit_q + IdxW'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tick_q  <= 3'd0;
            bit_q   <= '0;
            samp_q  <= 2'b00;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            samp_q  <= samp_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx8.sv
// Directed bench for uart_rx8: ticks every 4 clk, 32 clk per bit.
module tb_uart_rx8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud8_tick = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int dv0;
    int fe0;
    logic [1:0] tick_div = 2'd0;

    uart_rx8 #(
        .DATA_BITS  (8),
        .OVERSAMPLE (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud8_tick (baud8_tick),
        .rxd        (rxd),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_div   = tick_div + 2'd1;
        baud8_tick = (tick_div == 2'd0);
    end

    always @(negedge clk) begin
        if (data_valid) dv_cnt = dv_cnt + 1;
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (data_valid && frame_err) both_cnt = both_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        step(32);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            step(32);
        end
        rxd = stop_bit;
        step(32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        step(4);
        rst = 1'b0;
        step(2);
        chk("reset_data", 32'(data), 32'h00);
        chk("reset_valid", 32'(data_valid), 32'h0);
        chk("reset_ferr", 32'(frame_err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Clean 0x55 frame
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'h55, 1'b1);
        step(8);
        chk("f55_data", 32'(data), 32'h55);
        chk("f55_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
        chk("f55_fe_pulses", 32'(fe_cnt - fe0), 32'd0);
        chk("f55_busy_after", 32'(busy), 32'h0);

        // Quarter-bit glitch: false start
        dv0 = dv_cnt; fe0 = fe_cnt;
        rxd = 1'b0;
        step(8);
        rxd = 1'b1;
        step(64);
        chk("glitch_busy", 32'(busy), 32'h0);
        chk("glitch_dv", 32'(dv_cnt - dv0), 32'd0);
        chk("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
        chk("glitch_data", 32'(data), 32'h55);

        // 0xA3 with low stop bit, line held low 3 more bit times
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'hA3, 1'b0);
        step(96);
        chk("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("ferr_dv", 32'(dv_cnt - dv0), 32'd0);
        chk("ferr_data_hold", 32'(data), 32'h55);
        chk("break_busy", 32'(busy), 32'h1);
        rxd = 1'b1;
        step(32);
        chk("break_exit_busy", 32'(busy), 32'h0);
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'h3C, 1'b1);
        step(8);
        chk("f3c_data", 32'(data), 32'h3C);
        chk("f3c_dv", 32'(dv_cnt - dv0), 32'd1);
        chk("f3c_fe", 32'(fe_cnt - fe0), 32'd0);

        // Back-to-back 0x01 then 0xFF, no idle gap
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'h01, 1'b1);
        chk("b2b_first_data", 32'(data), 32'h01);
        chk("b2b_first_dv", 32'(dv_cnt - dv0), 32'd1);
        send_frame(8'hFF, 1'b1);
        step(8);
        chk("b2b_second_data", 32'(data), 32'hFF);
        chk("b2b_dv", 32'(dv_cnt - dv0), 32'd2);
        chk("b2b_fe", 32'(fe_cnt - fe0), 32'd0);

        // Reset during the data bits of 0x7E
        dv0 = dv_cnt; fe0 = fe_cnt;
        rxd = 1'b0;
        step(32);
        rxd = 1'b0;
        step(32);
        rxd = 1'b1;
        step(32);
        step(16);
        chk("mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        step(1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_data", 32'(data), 32'h00);
        rst = 1'b0;
        rxd = 1'b1;
        step(400);
        chk("rst_dv", 32'(dv_cnt - dv0), 32'd0);
        chk("rst_fe", 32'(fe_cnt - fe0), 32'd0);
        dv0 = dv_cnt;
        send_frame(8'h7E, 1'b1);
        step(8);
        chk("f7e_data", 32'(data), 32'h7E);
        chk("f7e_dv", 32'(dv_cnt - dv0), 32'd1);
        chk("f7e_fe", 32'(fe_cnt - fe0), 32'd0);

        chk("never_both", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
